// File: rtl/dacc_control_unit_if.sv
// Memory request/acknowledge bundle between the DACC sequencer and the memory port.
// The sequencer is the master: it raises mem_req (optionally qualified by mem_we)
// and selects the address source; memory answers with a one-cycle mem_ack pulse.
interface dacc_control_unit_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ack
    );
endinterface

// File: rtl/dacc_control_unit.sv
// dacc_control_unit: multi-cycle fetch/decode/execute sequencer for the
// double-accumulator datapath (ACC0/ACC1, ALU, PC, IR).
// Drives per-cycle control strobes, owns the memory req/ack handshake and a
// timeout watchdog that parks the machine in a sticky FAULT state.
// Optional feature: define DACC_SINGLE_STEP_EN to add the step_i input; every
// instruction then ends in the STEP state and waits for a step pulse.
module dacc_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dacc_control_unit_if.master    mem,
    input  logic                   run_i,
    input  logic [3:0]             opcode_i,
    input  logic                   acc_sel_i,
    input  logic                   zero0_i,
    input  logic                   zero1_i,
`ifdef DACC_SINGLE_STEP_EN
    input  logic                   step_i,
`endif
    output logic                   ir_load_o,
    output logic                   pc_inc_o,
    output logic                   pc_load_o,
    output logic [1:0]             acc_load_o,
    output logic [1:0]             acc_src_o,
    output logic [1:0]             alu_op_o,
    output logic [4:0]             state_o,
    output logic                   halted_o,
    output logic                   fault_o
);

    typedef enum logic [4:0] {
        S_IDLE   = 5'd0,
        S_FETCH  = 5'd1,
        S_FWAIT  = 5'd2,
        S_DECODE = 5'd3,
        S_RD     = 5'd4,
        S_RWAIT  = 5'd5,
        S_EXEC   = 5'd6,
        S_WR     = 5'd7,
        S_WWAIT  = 5'd8,
        S_SWP1   = 5'd9,
        S_SWP2   = 5'd10,
        S_BRANCH = 5'd11,
        S_INPUT  = 5'd12,
        S_HALT   = 5'd13,
        S_FAULT  = 5'd14,
        S_STEP   = 5'd15
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;

    state_t             boundaryState;
    logic               waitTimeout;
    logic               zeroSel;
    logic [1:0]         accOneHot;

    logic               memReq;
    logic               memWe;
    logic               addrSel;
    logic               irLoad;
    logic               pcInc;
    logic               pcLoad;
    logic [1:0]         accLoad;
    logic [1:0]         accSrc;
    logic [1:0]         aluOp;

    // Where an instruction goes when it finishes: the STEP parking state when
    // single-stepping, otherwise the next fetch, or IDLE if run has dropped.
    always_comb begin
`ifdef DACC_SINGLE_STEP_EN
        boundaryState = S_STEP;
`else
        boundaryState = run_i ? S_FETCH : S_IDLE;
`endif
    end

    // Watchdog limit: the wait cycle in which the counter would reach MEM_TIMEOUT.
    assign waitTimeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    assign zeroSel     = acc_sel_i ? zero1_i : zero0_i;
    assign accOneHot   = acc_sel_i ? 2'b10 : 2'b01;

    // Sequencer state and handshake watchdog; an ack in the timeout cycle wins over the fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_i) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    cnt_q   <= '0;
                    state_q <= S_FWAIT;
                end
                S_FWAIT: begin
                    if (mem.mem_ack)      state_q <= S_DECODE;
                    else if (waitTimeout) state_q <= S_FAULT;
                    else                  cnt_q   <= cnt_q + 1'b1;
                end
                S_DECODE: begin
                    case (opcode_i)
                        4'd0, 4'd2, 4'd3: state_q <= S_RD;
                        4'd1:             state_q <= S_WR;
                        4'd4:             state_q <= S_SWP1;
                        4'd5:             state_q <= S_BRANCH;
                        4'd6:             state_q <= zeroSel ? S_BRANCH : boundaryState;
                        4'd7:             state_q <= S_HALT;
                        4'd8:             state_q <= S_INPUT;
                        default:          state_q <= boundaryState;
                    endcase
                end
                S_RD: begin
                    cnt_q   <= '0;
                    state_q <= S_RWAIT;
                end
                S_RWAIT: begin
                    if (mem.mem_ack)      state_q <= S_EXEC;
                    else if (waitTimeout) state_q <= S_FAULT;
                    else                  cnt_q   <= cnt_q + 1'b1;
                end
                S_WR: begin
                    cnt_q   <= '0;
                    state_q <= S_WWAIT;
                end
                S_WWAIT: begin
                    if (mem.mem_ack)      state_q <= boundaryState;
                    else if (waitTimeout) state_q <= S_FAULT;
                    else                  cnt_q   <= cnt_q + 1'b1;
                end
                S_EXEC:   state_q <= boundaryState;
                S_SWP1:   state_q <= S_SWP2;
                S_SWP2:   state_q <= boundaryState;
                S_BRANCH: state_q <= boundaryState;
                S_INPUT:  state_q <= boundaryState;
                S_HALT:   state_q <= S_HALT;
                S_FAULT:  state_q <= S_FAULT;
`ifdef DACC_SINGLE_STEP_EN
                S_STEP: begin
                    if (step_i) state_q <= run_i ? S_FETCH : S_IDLE;
                end
`endif
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the control strobes from the registered state; only the
    // IR load / PC increment follow the ack pulse so the IR captures read data.
    always_comb begin
        memReq  = 1'b0;
        memWe   = 1'b0;
        addrSel = 1'b0;
        irLoad  = 1'b0;
        pcInc   = 1'b0;
        pcLoad  = 1'b0;
        accLoad = 2'b00;
        accSrc  = 2'b00;
        aluOp   = 2'b00;
        case (state_q)
            S_FETCH: memReq = 1'b1;
            S_FWAIT: begin
                memReq = 1'b1;
                irLoad = mem.mem_ack;
                pcInc  = mem.mem_ack;
            end
            S_RD, S_RWAIT: begin
                memReq  = 1'b1;
                addrSel = 1'b1;
            end
            S_EXEC: begin
                accLoad = accOneHot;
                if (opcode_i == 4'd2) begin
                    accSrc = 2'b01;
                    aluOp  = 2'b00;
                end else if (opcode_i == 4'd3) begin
                    accSrc = 2'b01;
                    aluOp  = 2'b01;
                end
            end
            S_WR, S_WWAIT: begin
                memReq  = 1'b1;
                memWe   = 1'b1;
                addrSel = 1'b1;
                aluOp   = 2'b10;
            end
            S_SWP1: aluOp = 2'b10;
            S_SWP2: begin
                accLoad = 2'b11;
                accSrc  = 2'b11;
            end
            S_BRANCH: pcLoad = 1'b1;
            S_INPUT: begin
                accLoad = accOneHot;
                accSrc  = 2'b10;
            end
            default: ;
        endcase
    end

    assign mem.mem_req  = memReq;
    assign mem.mem_we   = memWe;
    assign mem.addr_sel = addrSel;
    assign ir_load_o    = irLoad;
    assign pc_inc_o     = pcInc;
    assign pc_load_o    = pcLoad;
    assign acc_load_o   = accLoad;
    assign acc_src_o    = accSrc;
    assign alu_op_o     = aluOp;
    assign state_o      = state_q;
    assign halted_o     = (state_q == S_HALT);
    assign fault_o      = (state_q == S_FAULT);

endmodule

// File: tb/tb_dacc_control_unit.sv
// Testbench for dacc_control_unit: directed instruction sequences, each pushing
// its hand-derived per-cycle control trace into a queue that a negedge monitor
// pops and compares. A separate memory responder acks after a set latency.
module tb_dacc_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       accSel = 1'b0;
    logic       zero0 = 1'b0;
    logic       zero1 = 1'b0;
`ifdef DACC_SINGLE_STEP_EN
    logic       step = 1'b0;
`endif
    logic       irLoad, pcInc, pcLoad, halted, fault;
    logic [1:0] accLoad, accSrc, aluOp;
    logic [4:0] state;

    dacc_control_unit_if bus();

    dacc_control_unit #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus),
        .run_i      (run),
        .opcode_i   (opcode),
        .acc_sel_i  (accSel),
        .zero0_i    (zero0),
        .zero1_i    (zero1),
`ifdef DACC_SINGLE_STEP_EN
        .step_i     (step),
`endif
        .ir_load_o  (irLoad),
        .pc_inc_o   (pcInc),
        .pc_load_o  (pcLoad),
        .acc_load_o (accLoad),
        .acc_src_o  (accSrc),
        .alu_op_o   (aluOp),
        .state_o    (state),
        .halted_o   (halted),
        .fault_o    (fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] st;
        logic       irLoad;
        logic       pcInc;
        logic       pcLoad;
        logic       req;
        logic       we;
        logic       addrSel;
        logic [1:0] accLoad;
        logic [1:0] accSrc;
        logic [1:0] aluOp;
        logic       halted;
        logic       fault;
    } snap_t;

    typedef struct {
        snap_t s;
        string tag;
    } exp_t;

    exp_t  expQ[$];
    int    total = 0;
    int    bad = 0;
    int    pushed = 0;
    int    ackLat = 0;
    int    rcnt = 0;
    exp_t  monX;
    snap_t monA;

    // Memory responder: acks in the ackLat-th wait cycle of each access (0 = never).
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_ack = 1'b0;
            if (!rst_n) begin
                rcnt = 0;
            end else if (bus.mem_req) begin
                rcnt++;
                if (ackLat != 0 && rcnt == ackLat + 1) begin
                    bus.mem_ack = 1'b1;
                    rcnt = 0;
                end
            end
        end
    end

    // Monitor: every negedge with a pending expectation, compare the DUT snapshot.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                monX = expQ.pop_front();
                monA = {state, irLoad, pcInc, pcLoad, bus.mem_req, bus.mem_we, bus.addr_sel,
                        accLoad, accSrc, aluOp, halted, fault};
                total++;
                if (monA !== monX.s) begin
                    bad++;
                    $display("[TB] FAIL %s: got state=%0d bits=%h, expected state=%0d bits=%h",
                             monX.tag, monA.st, monA, monX.s.st, monX.s);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic snap_t blank(input logic [4:0] st);
        snap_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    task automatic push(input snap_t e, input string tag);
        exp_t x;
        x.s = e;
        x.tag = tag;
        expQ.push_back(x);
        pushed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushFetch(input int lat, input string tag);
        snap_t e;
        e = blank(5'd1); e.req = 1'b1;
        push(e, {tag, " fetch"});
        for (int i = 1; i <= lat; i++) begin
            e = blank(5'd2); e.req = 1'b1;
            if (i == lat) begin
                e.irLoad = 1'b1;
                e.pcInc = 1'b1;
            end
            push(e, {tag, " fwait"});
        end
    endtask

    task automatic pushRead(input int lat, input string tag);
        snap_t e;
        e = blank(5'd4); e.req = 1'b1; e.addrSel = 1'b1;
        push(e, {tag, " rd"});
        for (int i = 1; i <= lat; i++) begin
            e = blank(5'd5); e.req = 1'b1; e.addrSel = 1'b1;
            push(e, {tag, " rwait"});
        end
    endtask

    task automatic pushWrite(input int lat, input string tag);
        snap_t e;
        e = blank(5'd7); e.req = 1'b1; e.we = 1'b1; e.addrSel = 1'b1; e.aluOp = 2'b10;
        push(e, {tag, " wr"});
        for (int i = 1; i <= lat; i++) begin
            e = blank(5'd8); e.req = 1'b1; e.we = 1'b1; e.addrSel = 1'b1; e.aluOp = 2'b10;
            push(e, {tag, " wwait"});
        end
    endtask

    // Apply one instruction starting in a FETCH cycle and expect its full trace.
    task automatic applyStimulus(input logic [3:0] op, input logic sel, input int lat,
                                 input int park, input string tag);
        snap_t e;
        int    n;
        opcode = op;
        accSel = sel;
        ackLat = lat;
        pushed = 0;
        pushFetch(lat, tag);
        push(blank(5'd3), {tag, " decode"});
        case (op)
            4'd0, 4'd2, 4'd3: begin
                pushRead(lat, tag);
                e = blank(5'd6);
                e.accLoad = sel ? 2'b10 : 2'b01;
                e.accSrc  = (op == 4'd0) ? 2'b00 : 2'b01;
                e.aluOp   = (op == 4'd3) ? 2'b01 : 2'b00;
                push(e, {tag, " exec"});
            end
            4'd1: pushWrite(lat, tag);
            4'd4: begin
                e = blank(5'd9); e.aluOp = 2'b10;
                push(e, {tag, " swp1"});
                e = blank(5'd10); e.accLoad = 2'b11; e.accSrc = 2'b11;
                push(e, {tag, " swp2"});
            end
            4'd5: begin
                e = blank(5'd11); e.pcLoad = 1'b1;
                push(e, {tag, " branch"});
            end
            4'd6: begin
                if (sel ? zero1 : zero0) begin
                    e = blank(5'd11); e.pcLoad = 1'b1;
                    push(e, {tag, " branch"});
                end
            end
            4'd7: begin
                e = blank(5'd13); e.halted = 1'b1;
                push(e, {tag, " halt"});
            end
            4'd8: begin
                e = blank(5'd12); e.accLoad = sel ? 2'b10 : 2'b01; e.accSrc = 2'b10;
                push(e, {tag, " input"});
            end
            default: ;
        endcase
`ifdef DACC_SINGLE_STEP_EN
        if (op != 4'd7) begin
            for (int p = 0; p <= park; p++) push(blank(5'd15), {tag, " step"});
        end
`endif
        n = pushed;
        for (int i = 0; i < n; i++) begin
`ifdef DACC_SINGLE_STEP_EN
            step = (op != 4'd7 && i == n - 1);
`endif
            tick();
        end
`ifdef DACC_SINGLE_STEP_EN
        step = 1'b0;
`endif
    endtask

    // Drain the scoreboard; leftover expectations count as a failure.
    task automatic checkOutput();
        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
    endtask

    initial begin
        snap_t e;
        $display("[TB] start");
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            push(blank(5'd0), "reset");
            tick();
        end
        rst_n = 1'b1;
        run = 1'b1;
        push(blank(5'd0), "idle after reset");
        tick();

        applyStimulus(4'd8, 1'b0, 1, 0, "IN acc0");
        applyStimulus(4'd2, 1'b1, 3, 0, "ADD acc1 slow");
        applyStimulus(4'd3, 1'b0, 1, 0, "SUB acc0");
        applyStimulus(4'd0, 1'b1, 2, 0, "LDA acc1");
        applyStimulus(4'd1, 1'b1, 1, 0, "STA acc1");
        zero0 = 1'b1;
        applyStimulus(4'd6, 1'b0, 1, 0, "JZ0 taken");
        zero0 = 1'b0;
        zero1 = 1'b1;
        applyStimulus(4'd6, 1'b0, 1, 0, "JZ0 not taken");
        applyStimulus(4'd6, 1'b1, 1, 0, "JZ1 taken");
        zero1 = 1'b0;
        applyStimulus(4'd5, 1'b0, 1, 0, "JMP");
        applyStimulus(4'd12, 1'b0, 1, 2, "NOP");
        applyStimulus(4'd9, 1'b0, 15, 0, "ack at timeout limit");

        // run dropped mid-instruction: finish it, then sit in IDLE
        run = 1'b0;
        applyStimulus(4'd10, 1'b0, 1, 0, "NOP run low");
        push(blank(5'd0), "idle run low");
        tick();
        run = 1'b1;
        push(blank(5'd0), "idle run high");
        tick();

        // never acked fetch: 15 wait cycles then sticky FAULT
        opcode = 4'd0;
        ackLat = 0;
        e = blank(5'd1); e.req = 1'b1;
        push(e, "timeout fetch");
        for (int i = 0; i < 15; i++) begin
            e = blank(5'd2); e.req = 1'b1;
            push(e, "timeout fwait");
        end
        for (int i = 0; i < 3; i++) begin
            e = blank(5'd14); e.fault = 1'b1;
            push(e, "fault sticky");
        end
        for (int i = 0; i < 19; i++) begin
            if (i >= 16) run = ~run;
            tick();
        end
        rst_n = 1'b0;
        run = 1'b1;
        push(blank(5'd0), "fault cleared by reset");
        tick();
        rst_n = 1'b1;
        push(blank(5'd0), "idle after fault");
        tick();

        applyStimulus(4'd4, 1'b0, 1, 0, "SWAP");
        applyStimulus(4'd7, 1'b0, 1, 0, "HALT");
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            e = blank(5'd13); e.halted = 1'b1;
            push(e, "halt ignores run");
            tick();
        end
        rst_n = 1'b0;
        push(blank(5'd0), "halt cleared by reset");
        tick();
        rst_n = 1'b1;
        run = 1'b1;
        push(blank(5'd0), "idle after halt");
        tick();

        // reset asserted while a read waits for its ack
        opcode = 4'd0;
        accSel = 1'b0;
        ackLat = 1;
        pushFetch(1, "LDA abort");
        tick();
        tick();
        ackLat = 0;
        push(blank(5'd3), "LDA abort decode");
        tick();
        e = blank(5'd4); e.req = 1'b1; e.addrSel = 1'b1;
        push(e, "LDA abort rd");
        tick();
        e = blank(5'd5); e.req = 1'b1; e.addrSel = 1'b1;
        push(e, "LDA abort rwait");
        tick();
        rst_n = 1'b0;
        push(blank(5'd0), "async reset mid rwait");
        tick();
        push(blank(5'd0), "held in reset");
        tick();

        checkOutput();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
